vga_screen_seq: RTL and testbench

//  Game-screen sequencer feeding the VGA display path: owns the 4-bit screen state, both

---
 rtl/vga_screen_seq_pkg.sv | 39 +++
 rtl/vga_screen_seq_if.sv | 31 +++
 rtl/vga_screen_seq_sec_tick_gen.sv | 35 +++
 rtl/vga_screen_seq.sv | 158 +++++++++++++++
 tb/tb_vga_screen_seq.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_screen_seq_pkg.sv
// -----------------------------------------------------------------------------
// vga_screen_seq_pkg
//   Shared definitions for the game-screen sequencer and the pixel generator:
//   screen codes, the 4-bit digit type, the bundle of display-visible values
//   and a saturating round-counter helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package vga_screen_seq_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  // Screen codes seen by the pixel generator; values are part of the display contract.
  typedef enum logic [3:0] {
    SCR_IDLE      = 4'd0,
    SCR_COUNTDOWN = 4'd1,
    SCR_PLAY      = 4'd2,
    SCR_POINT     = 4'd3,
    SCR_OVER_P0   = 4'd4,
    SCR_OVER_P1   = 4'd5
  } screen_t;

  // Everything the display shows; live and committed copies share this layout
  // so a frame commit is a single whole-struct copy.
  typedef struct packed {
    screen_t state;
    digit_t  score0;
    digit_t  score1;
    digit_t  cnt0;
    digit_t  cnt1;
  } screen_view_t;

  // Round number stops at 9 (single display digit).
  function automatic digit_t sat_inc9(input digit_t d);
    return (d >= 4'd9) ? 4'd9 : d + 4'd1;
  endfunction

endpackage

// File: rtl/vga_screen_seq_if.sv
// -----------------------------------------------------------------------------
// vga_screen_seq_if
//   Bundle between game logic / VGA timing and the screen sequencer.
//   master : drives start, p0_point, p1_point, vsync; reads the committed
//            state, score0, score1, cnt0, cnt1.
//   slave  : the sequencer side (mirror of master).
// -----------------------------------------------------------------------------
interface vga_screen_seq_if;
  import vga_screen_seq_pkg::*;

  logic   start;     // one-cycle pulse: start game / acknowledge game over
  logic   p0_point;  // one-cycle pulse: player 0 scored
  logic   p1_point;  // one-cycle pulse: player 1 scored
  logic   vsync;     // VGA vsync, active-low, asynchronous to clk
  logic [3:0] state; // committed screen code
  digit_t score0;    // committed player 0 score
  digit_t score1;    // committed player 1 score
  digit_t cnt0;      // committed seconds remaining
  digit_t cnt1;      // committed round number

  modport master (
    output start, p0_point, p1_point, vsync,
    input  state, score0, score1, cnt0, cnt1
  );

  modport slave (
    input  start, p0_point, p1_point, vsync,
    output state, score0, score1, cnt0, cnt1
  );

endinterface

// File: rtl/vga_screen_seq_sec_tick_gen.sv
// -----------------------------------------------------------------------------
// sec_tick_gen
//   One-second prescaler. Counts 0..CLK_HZ-1 and pulses tick for the cycle in
//   which the count sits at CLK_HZ-1 (the wrap). clr restarts the count at 0,
//   so the first tick after a clr lands exactly CLK_HZ cycles later.
//   Ports: clk, rst (async, active-high), clr (in), tick (out, 1 cycle).
// -----------------------------------------------------------------------------
module sec_tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] count_reg;

  assign tick = (count_reg == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr || tick) begin
      // clr wins over the wrap so a state entry always restarts a full second
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/vga_screen_seq.sv
// -----------------------------------------------------------------------------
// vga_screen_seq
//   Game-screen sequencer: title -> countdown -> play -> point pause -> game
//   over. Holds the live screen state, scores, countdown digit and round
//   number, and republishes them to the display only on a vsync falling edge
//   so a frame never shows a half-updated set of values.
//   Ports:
//     clk  system clock
//     rst  asynchronous active-high reset (clears live and committed values)
//     bus  vga_screen_seq_if.slave: start/p0_point/p1_point/vsync in,
//          state/score0/score1/cnt0/cnt1 out (committed copies)
// -----------------------------------------------------------------------------
module vga_screen_seq
  import vga_screen_seq_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int COUNT_SEC = 3,
  parameter int POINT_SEC = 2,
  parameter int WIN_SCORE = 5
) (
  input  logic                clk,
  input  logic                rst,
  vga_screen_seq_if.slave     bus
);

  localparam digit_t COUNT_D = digit_t'(COUNT_SEC);
  localparam digit_t POINT_D = digit_t'(POINT_SEC);
  localparam digit_t WIN_D   = digit_t'(WIN_SCORE);

  screen_view_t live_reg;  // what the game is doing right now
  screen_view_t view_reg;  // what the display is allowed to see

  logic   tick;
  logic   tick_clr;
  logic   one_point;
  digit_t scored_next;
  logic   timer_done;

  // vsync is from another clock domain: two flops, then a third for edge detect.
  // All three rest high so reset never fakes a falling edge.
  logic vs_meta_reg;
  logic vs_sync_reg;
  logic vs_prev_reg;
  logic frame_go;

  sec_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  // A tie (both players in the same cycle) counts as no point at all.
  assign one_point   = bus.p0_point ^ bus.p1_point;
  assign scored_next = bus.p0_point ? live_reg.score0 + 4'd1 : live_reg.score1 + 4'd1;
  assign timer_done  = tick && (live_reg.cnt0 <= 4'd1);

  // Restart the prescaler on every entry to a timed screen (COUNTDOWN or POINT).
  always_comb begin
    tick_clr = 1'b0;
    case (live_reg.state)
      SCR_IDLE:  tick_clr = bus.start;
      SCR_PLAY:  tick_clr = one_point && (scored_next != WIN_D);
      SCR_POINT: tick_clr = timer_done;
      default:   tick_clr = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_reg <= '0;
    end else begin
      case (live_reg.state)
        SCR_IDLE: begin
          if (bus.start) begin
            live_reg.state  <= SCR_COUNTDOWN;
            live_reg.score0 <= '0;
            live_reg.score1 <= '0;
            live_reg.cnt0   <= COUNT_D;
            live_reg.cnt1   <= sat_inc9(live_reg.cnt1);
          end
        end

        SCR_COUNTDOWN: begin
          if (timer_done) begin
            live_reg.state <= SCR_PLAY;
            live_reg.cnt0  <= '0;
          end else if (tick) begin
            live_reg.cnt0 <= live_reg.cnt0 - 4'd1;
          end
        end

        SCR_PLAY: begin
          if (one_point) begin
            if (bus.p0_point) live_reg.score0 <= scored_next;
            else              live_reg.score1 <= scored_next;
            // Leaving PLAY on the winning point is what keeps scores <= WIN_SCORE.
            if (scored_next == WIN_D) begin
              live_reg.state <= bus.p0_point ? SCR_OVER_P0 : SCR_OVER_P1;
              live_reg.cnt0  <= '0;
            end else begin
              live_reg.state <= SCR_POINT;
              live_reg.cnt0  <= POINT_D;
            end
          end
        end

        SCR_POINT: begin
          if (timer_done) begin
            live_reg.state <= SCR_COUNTDOWN;
            live_reg.cnt0  <= COUNT_D;
            live_reg.cnt1  <= sat_inc9(live_reg.cnt1);
          end else if (tick) begin
            live_reg.cnt0 <= live_reg.cnt0 - 4'd1;
          end
        end

        SCR_OVER_P0, SCR_OVER_P1: begin
          if (bus.start) live_reg <= '0;
        end

        default: live_reg <= '0;  // unused codes fall back to the title screen
      endcase
    end
  end

  assign frame_go = vs_prev_reg & ~vs_sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_meta_reg <= 1'b1;
      vs_sync_reg <= 1'b1;
      vs_prev_reg <= 1'b1;
    end else begin
      vs_meta_reg <= bus.vsync;
      vs_sync_reg <= vs_meta_reg;
      vs_prev_reg <= vs_sync_reg;
    end
  end

  // Whole-struct copy: a same-cycle live update lands next frame, never half-applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      view_reg <= '0;
    end else if (frame_go) begin
      view_reg <= live_reg;
    end
  end

  assign bus.state  = view_reg.state;
  assign bus.score0 = view_reg.score0;
  assign bus.score1 = view_reg.score1;
  assign bus.cnt0   = view_reg.cnt0;
  assign bus.cnt1   = view_reg.cnt1;

endmodule

// File: tb/tb_vga_screen_seq.sv
// -----------------------------------------------------------------------------
// tb_vga_screen_seq
//   Scoreboard bench: a cycle-level reference of the game rules pushes every
//   newly committed display value into a queue; a monitor on the falling clock
//   edge pops and compares, and otherwise requires the outputs to hold.
// -----------------------------------------------------------------------------
module tb_vga_screen_seq;
  import vga_screen_seq_pkg::*;

  localparam int CLK_HZ    = 10;
  localparam int COUNT_SEC = 3;
  localparam int POINT_SEC = 2;
  localparam int WIN_SCORE = 2;
  localparam int VS_HALF   = 7;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] s0;
    logic [3:0] s1;
    logic [3:0] c0;
    logic [3:0] c1;
  } view_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vs_en = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  vga_screen_seq_if bus();

  vga_screen_seq #(
    .CLK_HZ    (CLK_HZ),
    .COUNT_SEC (COUNT_SEC),
    .POINT_SEC (POINT_SEC),
    .WIN_SCORE (WIN_SCORE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (game rules, elapsed-cycle timing) -------
  int    m_st = 0, m_s0 = 0, m_s1 = 0, m_c0 = 0, m_c1 = 0, m_el = 0;
  logic [2:0] vs_hist = 3'b111;  // vsync seen at the last three edges, [0] newest
  view_t m_out = '0;
  view_t exp_q[$];

  function automatic view_t model_live();
    view_t v;
    v.st = 4'(m_st); v.s0 = 4'(m_s0); v.s1 = 4'(m_s1);
    v.c0 = 4'(m_c0); v.c1 = 4'(m_c1);
    return v;
  endfunction

  function automatic view_t dut_view();
    return {bus.state, bus.score0, bus.score1, bus.cnt0, bus.cnt1};
  endfunction

  function automatic int next_round(input int r);
    return (r + 1 > 9) ? 9 : r + 1;
  endfunction

  task automatic model_step(input logic s, input logic a, input logic b);
    case (m_st)
      0: if (s) begin
           m_st = 1; m_s0 = 0; m_s1 = 0; m_c0 = COUNT_SEC;
           m_c1 = next_round(m_c1); m_el = 0;
         end
      1, 3: begin
        m_el++;
        if (m_el == CLK_HZ) begin  // one full second has elapsed in this screen
          m_el = 0;
          if (m_c0 > 1) m_c0--;
          else if (m_st == 1) begin m_st = 2; m_c0 = 0; end
          else begin m_st = 1; m_c0 = COUNT_SEC; m_c1 = next_round(m_c1); end
        end
      end
      2: if (a != b) begin
           if (a) m_s0++; else m_s1++;
           if ((a ? m_s0 : m_s1) == WIN_SCORE) begin m_st = a ? 4 : 5; m_c0 = 0; end
           else begin m_st = 3; m_c0 = POINT_SEC; m_el = 0; end
         end
      default: if (s) begin
           m_st = 0; m_s0 = 0; m_s1 = 0; m_c0 = 0; m_c1 = 0;
         end
    endcase
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_st = 0; m_s0 = 0; m_s1 = 0; m_c0 = 0; m_c1 = 0; m_el = 0;
      vs_hist = 3'b111; m_out = '0; exp_q.delete();
    end else begin
      // Display takes the live values from before this edge, three edges after vsync fell.
      if (vs_hist[2] && !vs_hist[1]) begin
        if (model_live() != m_out) begin
          m_out = model_live();
          exp_q.push_back(m_out);
        end
      end
      vs_hist = {vs_hist[1:0], bus.vsync};
      model_step(bus.start, bus.p0_point, bus.p1_point);
    end
  end

  // ---------------- monitor ---------------------------------------------------
  view_t mon_last = '0;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      mon_last = '0;
    end else if (exp_q.size() > 0) begin
      view_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (dut_view() !== e) begin
        n_fail++;
        $display("FAIL commit @%0t: {st,s0,s1,c0,c1} got=%h required=%h", $time, dut_view(), e);
      end
      mon_last = e;
    end else begin
      n_cmp++;
      if (dut_view() !== mon_last) begin
        n_fail++;
        $display("FAIL hold @%0t: {st,s0,s1,c0,c1} got=%h required=%h", $time, dut_view(), mon_last);
      end
    end
  end

  // ---------------- vsync generator -------------------------------------------
  initial begin
    int vcnt;
    vcnt = 0;
    bus.vsync = 1'b1;
    forever begin
      @(negedge clk);
      if (vs_en) begin
        vcnt++;
        if (vcnt == VS_HALF) begin vcnt = 0; bus.vsync = ~bus.vsync; end
      end else begin
        vcnt = 0; bus.vsync = 1'b1;
      end
    end
  end

  // ---------------- stimulus --------------------------------------------------
  task automatic pulse(input logic s, input logic a, input logic b);
    @(negedge clk);
    bus.start = s; bus.p0_point = a; bus.p1_point = b;
    @(negedge clk);
    bus.start = 1'b0; bus.p0_point = 1'b0; bus.p1_point = 1'b0;
  endtask

  task automatic wait_screen(input int target, input int max_cyc, input string what);
    int n;
    n = 0;
    while (m_st != target && n < max_cyc) begin @(negedge clk); n++; end
    if (m_st != target) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout %s: screen=%0d required=%0d", what, m_st, target);
    end
  endtask

  task automatic check_now(input string what, input view_t req);
    n_cmp++;
    if (dut_view() !== req) begin
      n_fail++;
      $display("FAIL %s: {st,s0,s1,c0,c1} got=%h required=%h", what, dut_view(), req);
    end
  endtask

  initial begin
    int n;
    bus.start = 1'b0; bus.p0_point = 1'b0; bus.p1_point = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_now("reset", 20'h00000);

    // No vsync edges yet: game advances, display stays blank.
    pulse(1'b1, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check_now("no_vsync", 20'h00000);
    vs_en = 1'b1;

    wait_screen(2, 200, "play1");
    pulse(1'b0, 1'b1, 1'b0);           // p0 scores -> POINT
    wait_screen(2, 200, "play2");
    pulse(1'b0, 1'b1, 1'b1);           // tie, ignored
    repeat (30) @(negedge clk);
    check_now("tie", 20'h21002);
    pulse(1'b0, 1'b0, 1'b1);           // p1 -> 1
    wait_screen(2, 200, "play3");
    pulse(1'b0, 1'b0, 1'b1);           // p1 -> 2, wins
    repeat (30) @(negedge clk);
    check_now("over_p1", 20'h51203);
    pulse(1'b0, 1'b0, 1'b1);           // ignored in OVER
    repeat (30) @(negedge clk);
    check_now("over_extra_point", 20'h51203);
    pulse(1'b1, 1'b0, 1'b0);           // acknowledge -> IDLE
    repeat (30) @(negedge clk);
    check_now("over_to_idle", 20'h00000);

    // Reset in the middle of a countdown.
    pulse(1'b1, 1'b0, 1'b0);
    n = 0;
    while (!(m_st == 1 && m_c0 == 2) && n < 100) begin @(negedge clk); n++; end
    repeat (16) @(negedge clk);        // let the display catch up to a nonzero value
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_now("async_rst", 20'h00000);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Start during POINT must be ignored.
    pulse(1'b1, 1'b0, 1'b0);
    wait_screen(2, 200, "play4");
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    wait_screen(2, 200, "play5");

    // Random play, with a stretch of stuck vsync in the middle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == 1000) vs_en = 1'b0;
      if (i == 1200) vs_en = 1'b1;
      bus.start    = ($urandom_range(0, 24) == 0);
      bus.p0_point = ($urandom_range(0, 14) == 0);
      bus.p1_point = ($urandom_range(0, 14) == 0);
    end
    @(negedge clk);
    bus.start = 1'b0; bus.p0_point = 1'b0; bus.p1_point = 1'b0;
    repeat (40) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
